song_bank_memory: RTL
=====================

// Module: song_bank_memory
// PURPOSE
//  Multi-bank note/song store for the organ datapath: NUM_BANKS independent record buffers in one RAM.
//  Appends recorded notes to the selected bank and plays them back in order with a valid strobe.
//  Supports optional loop playback and per-bank clear. Sits between the keyboard/recorder and the
//  autoplay/learning players, so one instance serves all play modes.
// PARAMETERS
//  DATA_WIDTH  8    bits per stored note word
//  DEPTH       256  words per bank (power of two, >=2)
//  NUM_BANKS   4    number of independent banks (power of two, >=1)
//  AW = $clog2(DEPTH), BW = max(1,$clog2(NUM_BANKS))  (localparams)
// PORTS
//  clk        in   1           system clock, all state on rising edge
//  rst_n      in   1           asynchronous active-low reset
//  bank_sel   in   BW          bank addressed by write, read and clear
//  wr_en      in   1           append wr_data to selected bank
//  wr_data    in   DATA_WIDTH  note word to store
//  rd_en      in   1           request next word of selected bank
//  rd_rst     in   1           rewind read pointer to 0
//  loop_en    in   1           1: playback wraps to word 0 after last word
//  clr_bank   in   1           set selected bank length to 0
//  rd_data    out  DATA_WIDTH  word read, valid when rd_valid
//  rd_valid   out  1           1-cycle strobe, rd_data valid
//  rd_done    out  1           1-cycle strobe, end of bank reached (no loop)
//  wr_full    out  1           selected bank holds DEPTH words
//  wr_ovf     out  1           1-cycle strobe, write dropped because bank full
//  bank_len   out  AW+1        word count of selected bank
// BEHAVIOUR
//  Reset: all bank lengths 0, rd_ptr 0, rd_data 0, rd_valid/rd_done/wr_ovf 0. RAM contents not reset.
//  Storage: one synchronous RAM, NUM_BANKS*DEPTH words, address {bank_sel, ptr}.
//  Write: wr_en & !full -> mem[{bank,len}] <= wr_data, len+1 next edge. Full -> no write, wr_ovf=1 next cycle.
//  Read, latency 1: rd_en sampled at edge N; rd_data/rd_valid update at edge N+1.
//   rd_ptr < len: rd_data=mem[{bank,rd_ptr}], rd_valid=1, rd_ptr+1.
//   rd_ptr == len, loop_en=1, len>0: return word 0, rd_valid=1, rd_ptr<=1.
//   rd_ptr == len, loop_en=0 or len=0: rd_valid=0, rd_done=1, rd_ptr holds.
//  rd_data holds its last value when rd_valid=0.
//  rd_ptr is AW+1 bits, compared against len; there is no modulo wrap inside a bank.
//  Rewind: rd_rst=1, or bank_sel differs from the previous cycle's value -> rd_ptr<=0.
//   Rewind has priority over rd_en that cycle: no read, rd_valid=0.
//  Clear: clr_bank -> selected len<=0 and rd_ptr<=0. Beats wr_en and rd_en in the same cycle.
//   Dropped wr_en gives no wr_ovf.
//  Same bank, same cycle write+read: the read compares against the pre-write len.
//   The new word is visible from the next cycle.
//  wr_full and bank_len are combinational from the selected bank's registered len.
//  Only the selected bank is touched; other banks' lengths never change.
// TESTING
//  T1 reset, bank 0, write 0x11,0x22,0x33 -> bank_len=3. rd_en 4 cycles ->
//     rd_data 0x11,0x22,0x33 (each rd_valid=1 one cycle later), then rd_done=1 with rd_valid=0.
//  T2 bank 0 has 3 words, loop_en=1, rd_en 5 cycles -> 0x11,0x22,0x33,0x11,0x22 back-to-back, rd_done never 1.
//  T3 fill bank 2 with DEPTH words -> wr_full=1. Write 0xAA -> wr_ovf pulse, bank_len=DEPTH, last word unchanged.
//  T4 record bank 1 (0x05) and bank 3 (0x07). Read bank 1, switch bank_sel to 3 mid-stream ->
//     first read after switch gives 0x07. Bank 1 bank_len still 1.
//  T5 write and rd_en same cycle on an empty bank -> rd_done=1, no valid. Next rd_en -> the written word, rd_valid=1.
//  T6 rst_n low mid-playback (async, between edges) -> outputs 0 at once, all bank_len=0.
//     clr_bank with wr_en -> len 0, no write, no wr_ovf.

Source files
------------

// File: rtl/song_bank_memory.sv
// song_bank_memory: multi-bank note store for the organ datapath.
// Each bank is an append-only record buffer. All banks live in one
// synchronous RAM addressed as {bank, word}. A single read pointer
// plays the selected bank back in order, with optional looping.
// Changing banks or asserting rd_rst rewinds the read pointer.
module song_bank_memory #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int NUM_BANKS  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [((NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1)-1:0] bank_sel,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          rd_en,
  input  logic                          rd_rst,
  input  logic                          loop_en,
  input  logic                          clr_bank,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          rd_valid,
  output logic                          rd_done,
  output logic                          wr_full,
  output logic                          wr_ovf,
  output logic [$clog2(DEPTH):0]        bank_len
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  logic [DATA_WIDTH-1:0] mem [NUM_BANKS*DEPTH];
  logic [AW:0]           lens [NUM_BANKS];

  logic [BW-1:0]  bank;
  logic [BW-1:0]  prev_bank;
  logic [AW:0]    rd_ptr;
  logic [AW:0]    len_cur;
  logic           full;
  logic           rewind;
  logic           do_write;
  logic           ovf_next;
  logic           have_word;
  logic           loop_wrap;
  logic [AW+BW-1:0] rd_addr;
  logic [AW+BW-1:0] wr_addr;

  // A single-bank build has a dummy select bit that must never index past bank 0.
  assign bank = (NUM_BANKS > 1) ? bank_sel : '0;

  assign len_cur  = lens[bank];
  assign full     = (len_cur == (AW+1)'(DEPTH));
  assign wr_full  = full;
  assign bank_len = len_cur;

  // Clearing also rewinds, and it suppresses both the write and the read that cycle.
  assign rewind    = rd_rst | (bank != prev_bank) | clr_bank;
  assign do_write  = wr_en & ~clr_bank & ~full;
  assign ovf_next  = wr_en & ~clr_bank & full;

  // The read decision uses the pre-write length, so a same-cycle append is not yet visible.
  assign have_word = (rd_ptr < len_cur);
  assign loop_wrap = ~have_word & loop_en & (len_cur != '0);
  assign rd_addr   = {bank, (have_word ? rd_ptr[AW-1:0] : {AW{1'b0}})};
  assign wr_addr   = {bank, len_cur[AW-1:0]};

  // Per-bank word counts: clear wins over append; other banks are never touched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        lens[i] <= '0;
      end
    end else if (clr_bank) begin
      lens[bank] <= '0;
    end else if (do_write) begin
      lens[bank] <= len_cur + 1'b1;
    end
  end

  // Note storage itself is deliberately not reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Playback pointer, registered read data and the one-cycle status strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      rd_done   <= 1'b0;
      wr_ovf    <= 1'b0;
      prev_bank <= '0;
    end else begin
      rd_valid  <= 1'b0;
      rd_done   <= 1'b0;
      wr_ovf    <= ovf_next;
      prev_bank <= bank;
      if (rewind) begin
        rd_ptr <= '0;
      end else if (rd_en) begin
        if (have_word) begin
          rd_data  <= mem[rd_addr];
          rd_valid <= 1'b1;
          rd_ptr   <= rd_ptr + 1'b1;
        end else if (loop_wrap) begin
          rd_data  <= mem[rd_addr];
          rd_valid <= 1'b1;
          rd_ptr   <= (AW+1)'(1);
        end else begin
          rd_done  <= 1'b1;
        end
      end
    end
  end

endmodule
